// File: rtl/arith_seq_ctrl.sv
// Local program sequencer for iterative multiply, divide and I/O digit shift.
// Emits one-cycle micro-operation pulses to the arithmetic unit, decoded from the current state.
module arith_seq_ctrl #(
    parameter int WORD_W       = 30,
    parameter int CNT_W        = 5,
    parameter int IO_SHIFT_MAX = 4,
    parameter int IO_SEL_W     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_from_pu,
    input  logic                order_mul_from_op,
    input  logic                order_div_from_op,
    input  logic                order_io_from_io,
    input  logic [IO_SEL_W-1:0] io_shift_bits_from_io,
    input  logic                carry_out_from_au,
    input  logic                reg_c_lsb_from_au,
    input  logic                reg_b0_from_au,
    input  logic                sign_a_from_au,
    input  logic                sign_b_from_au,
    output logic                do_clear_b_to_au,
    output logic                do_not_a_to_au,
    output logic                do_sum_to_au,
    output logic                do_right_shift_bc_to_au,
    output logic                do_left_shift_b_to_au,
    output logic                do_left_shift_c_to_au,
    output logic                do_set_c_lsb_to_au,
    output logic                do_move_b_to_c_to_au,
    output logic                do_move_c_to_b_to_au,
    output logic                do_write_sign_to_au,
    output logic                result_sign_to_au,
    output logic                ac_answer_to_op,
    output logic                ac_answer_to_io,
    output logic                overflow_to_op,
    output logic                busy_to_op
);

    typedef enum logic [3:0] {
        IDLE, M_INIT, M_ADD, M_SHIFT, M_DONE,
        D_INIT, D_CHECK, D_OVF, D_SHIFT, D_STEP, D_DONE,
        IO_SHIFT, IO_DONE
    } state_t;

    localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(WORD_W - 1);
    localparam logic [IO_SEL_W-1:0] IO_MAX    = IO_SEL_W'(IO_SHIFT_MAX);

    state_t                state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [IO_SEL_W-1:0]   shift_n_reg;
    logic [IO_SEL_W-1:0]   io_clamped;
    logic [IO_SEL_W-1:0]   io_last;
    logic                  iter_last;
    logic                  io_end;

    assign io_clamped = (io_shift_bits_from_io > IO_MAX) ? IO_MAX : io_shift_bits_from_io;
    assign io_last    = shift_n_reg - 1'b1;
    assign iter_last  = (cnt_reg == LAST_ITER);
    assign io_end     = (CNT_W'(io_last) == cnt_reg);

    always_ff @(posedge clk) begin
        if (reset || clear_from_pu) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            shift_n_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (order_mul_from_op) begin
                        state_reg <= M_INIT;
                    end else if (order_div_from_op) begin
                        state_reg <= D_INIT;
                    end else if (order_io_from_io) begin
                        shift_n_reg <= io_clamped;
                        state_reg   <= (io_clamped == '0) ? IO_DONE : IO_SHIFT;
                    end
                end
                M_INIT:  state_reg <= M_ADD;
                M_ADD:   state_reg <= M_SHIFT;
                M_SHIFT: begin
                    if (iter_last) begin
                        cnt_reg   <= '0;
                        state_reg <= M_DONE;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                        state_reg <= M_ADD;
                    end
                end
                M_DONE:  state_reg <= IDLE;
                D_INIT:  state_reg <= D_CHECK;
                // A carry on the trial subtract means the quotient cannot fit.
                D_CHECK: state_reg <= carry_out_from_au ? D_OVF : D_SHIFT;
                D_OVF:   state_reg <= IDLE;
                D_SHIFT: state_reg <= D_STEP;
                D_STEP: begin
                    if (iter_last) begin
                        cnt_reg   <= '0;
                        state_reg <= D_DONE;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                        state_reg <= D_SHIFT;
                    end
                end
                D_DONE:  state_reg <= IDLE;
                IO_SHIFT: begin
                    if (io_end) begin
                        cnt_reg   <= '0;
                        state_reg <= IO_DONE;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                    end
                end
                IO_DONE: state_reg <= IDLE;
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        do_clear_b_to_au        = 1'b0;
        do_not_a_to_au          = 1'b0;
        do_sum_to_au            = 1'b0;
        do_right_shift_bc_to_au = 1'b0;
        do_left_shift_b_to_au   = 1'b0;
        do_left_shift_c_to_au   = 1'b0;
        do_set_c_lsb_to_au      = 1'b0;
        do_move_b_to_c_to_au    = 1'b0;
        do_move_c_to_b_to_au    = 1'b0;
        do_write_sign_to_au     = 1'b0;
        ac_answer_to_op         = 1'b0;
        ac_answer_to_io         = 1'b0;
        overflow_to_op          = 1'b0;
        case (state_reg)
            M_INIT: begin
                do_clear_b_to_au    = 1'b1;
                do_write_sign_to_au = 1'b1;
            end
            M_ADD:   do_sum_to_au            = reg_c_lsb_from_au;
            M_SHIFT: do_right_shift_bc_to_au = 1'b1;
            M_DONE: begin
                do_move_b_to_c_to_au = 1'b1;
                ac_answer_to_op      = 1'b1;
            end
            D_INIT: begin
                do_not_a_to_au      = 1'b1;
                do_write_sign_to_au = 1'b1;
            end
            D_OVF: begin
                ac_answer_to_op = 1'b1;
                overflow_to_op  = 1'b1;
            end
            D_SHIFT: begin
                do_left_shift_b_to_au = 1'b1;
                do_left_shift_c_to_au = 1'b1;
            end
            D_STEP: begin
                do_sum_to_au       = (carry_out_from_au != reg_b0_from_au);
                do_set_c_lsb_to_au = (carry_out_from_au != reg_b0_from_au);
            end
            D_DONE: begin
                do_move_c_to_b_to_au = 1'b1;
                ac_answer_to_op      = 1'b1;
            end
            IO_SHIFT: do_left_shift_c_to_au = 1'b1;
            IO_DONE:  ac_answer_to_io       = 1'b1;
            default: ;
        endcase
    end

    assign result_sign_to_au = sign_a_from_au ^ sign_b_from_au;
    assign busy_to_op        = (state_reg != IDLE);

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Directed bench for arith_seq_ctrl: counts pulses and answer timing per order.
// A second WORD_W=8 instance shares all inputs to check the parametrised latency.
module tb_arith_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear_from_pu = 1'b0;
    logic       order_mul = 1'b0, order_div = 1'b0, order_io = 1'b0;
    logic [2:0] io_bits = 3'd0;
    logic       carry_out = 1'b0, reg_c_lsb = 1'b0, reg_b0 = 1'b0;
    logic       sign_a = 1'b0, sign_b = 1'b0;

    logic clr_b, not_a, sum, rsh_bc, lsh_b, lsh_c, set_c, mv_bc, mv_cb, wr_sign;
    logic res_sign, ans_op, ans_io, ovf, busy;
    logic e_clr_b, e_not_a, e_sum, e_rsh_bc, e_lsh_b, e_lsh_c, e_set_c, e_mv_bc, e_mv_cb, e_wr_sign;
    logic e_res_sign, e_ans_op, e_ans_io, e_ovf, e_busy;

    always #5 clk = ~clk;

    arith_seq_ctrl u_dut (
        .clk(clk), .reset(reset), .clear_from_pu(clear_from_pu),
        .order_mul_from_op(order_mul), .order_div_from_op(order_div),
        .order_io_from_io(order_io), .io_shift_bits_from_io(io_bits),
        .carry_out_from_au(carry_out), .reg_c_lsb_from_au(reg_c_lsb),
        .reg_b0_from_au(reg_b0), .sign_a_from_au(sign_a), .sign_b_from_au(sign_b),
        .do_clear_b_to_au(clr_b), .do_not_a_to_au(not_a), .do_sum_to_au(sum),
        .do_right_shift_bc_to_au(rsh_bc), .do_left_shift_b_to_au(lsh_b),
        .do_left_shift_c_to_au(lsh_c), .do_set_c_lsb_to_au(set_c),
        .do_move_b_to_c_to_au(mv_bc), .do_move_c_to_b_to_au(mv_cb),
        .do_write_sign_to_au(wr_sign), .result_sign_to_au(res_sign),
        .ac_answer_to_op(ans_op), .ac_answer_to_io(ans_io),
        .overflow_to_op(ovf), .busy_to_op(busy)
    );

    arith_seq_ctrl #(.WORD_W(8), .CNT_W(3)) u_dut8 (
        .clk(clk), .reset(reset), .clear_from_pu(clear_from_pu),
        .order_mul_from_op(order_mul), .order_div_from_op(order_div),
        .order_io_from_io(order_io), .io_shift_bits_from_io(io_bits),
        .carry_out_from_au(carry_out), .reg_c_lsb_from_au(reg_c_lsb),
        .reg_b0_from_au(reg_b0), .sign_a_from_au(sign_a), .sign_b_from_au(sign_b),
        .do_clear_b_to_au(e_clr_b), .do_not_a_to_au(e_not_a), .do_sum_to_au(e_sum),
        .do_right_shift_bc_to_au(e_rsh_bc), .do_left_shift_b_to_au(e_lsh_b),
        .do_left_shift_c_to_au(e_lsh_c), .do_set_c_lsb_to_au(e_set_c),
        .do_move_b_to_c_to_au(e_mv_bc), .do_move_c_to_b_to_au(e_mv_cb),
        .do_write_sign_to_au(e_wr_sign), .result_sign_to_au(e_res_sign),
        .ac_answer_to_op(e_ans_op), .ac_answer_to_io(e_ans_io),
        .overflow_to_op(e_ovf), .busy_to_op(e_busy)
    );

    wire [12:0] all_pulses = {clr_b, not_a, sum, rsh_bc, lsh_b, lsh_c, set_c,
                              mv_bc, mv_cb, wr_sign, ans_op, ans_io, ovf};

    int n_checks = 0;
    int n_pass = 0;

    int c_clrb, c_nota, c_sum, c_rsh, c_lshb, c_lshc, c_setc, c_mbc, c_mcb, c_ws;
    int c_ans_op, c_ans_io, c_ovf, c_busy, c_late;
    int t_ans_op, t_ans_io, t_ovf, t_busy_first, t_busy_last, t_d8_ans, ws_sign;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // pat 1: multiplier bit high on cycles 2,6,10..; pat 2: b0 high on cycles 4,8,..;
    // pat 3: carry high in cycle 2 only.
    task automatic set_levels(input int pat, input int cyc);
        reg_c_lsb = (pat == 1) && (cyc % 4 == 2);
        reg_b0    = (pat == 2) && (cyc % 4 == 0);
        carry_out = (pat == 3) && (cyc == 2);
    endtask

    task automatic run(input string name, input logic m, input logic d, input logic i,
                       input logic [2:0] bits, input int pat, input int io_cyc,
                       input int clr_cyc, input int rst_cyc, input int stop_cyc);
        int cyc;
        {c_clrb, c_nota, c_sum, c_rsh, c_lshb, c_lshc, c_setc, c_mbc, c_mcb, c_ws} = '0;
        {c_ans_op, c_ans_io, c_ovf, c_busy, c_late} = '0;
        t_ans_op = -1; t_ans_io = -1; t_ovf = -1; t_busy_first = -1; t_busy_last = -1;
        t_d8_ans = -1; ws_sign = -1;
        @(posedge clk); #1;
        cyc = 0;
        order_mul = m; order_div = d; order_io = i; io_bits = bits;
        set_levels(pat, 0);
        while (cyc <= stop_cyc) begin
            @(negedge clk);
            c_clrb += clr_b; c_nota += not_a; c_sum += sum; c_rsh += rsh_bc;
            c_lshb += lsh_b; c_lshc += lsh_c; c_setc += set_c; c_mbc += mv_bc;
            c_mcb += mv_cb;
            if (wr_sign) begin c_ws++; ws_sign = res_sign; end
            if (ans_op) begin c_ans_op++; t_ans_op = cyc; end
            if (ans_io) begin c_ans_io++; t_ans_io = cyc; end
            if (ovf) begin c_ovf++; t_ovf = cyc; end
            if (busy) begin
                c_busy++; t_busy_last = cyc;
                if (t_busy_first < 0) t_busy_first = cyc;
            end
            if (e_ans_op && t_d8_ans < 0) t_d8_ans = cyc;
            if (rst_cyc >= 0 && cyc > rst_cyc && all_pulses != '0) c_late++;
            @(posedge clk); #1;
            cyc++;
            order_mul = 1'b0; order_div = 1'b0;
            order_io = (cyc == io_cyc);
            clear_from_pu = (cyc == clr_cyc);
            reset = (cyc == rst_cyc);
            set_levels(pat, cyc);
        end
        clear_from_pu = 1'b0; reset = 1'b0; order_io = 1'b0;
        $display("run %-10s ans_op@%0d ans_io@%0d ovf@%0d busy %0d..%0d sum=%0d lshc=%0d",
                 name, t_ans_op, t_ans_io, t_ovf, t_busy_first, t_busy_last, c_sum, c_lshc);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_pulses", int'(all_pulses), 0);

        sign_a = 1'b1; sign_b = 1'b0;
        run("mul", 1, 0, 0, 3'd0, 1, -1, -1, -1, 66);
        check("mul_sum", c_sum, 15);
        check("mul_rsh", c_rsh, 30);
        check("mul_clrb", c_clrb, 1);
        check("mul_ws", c_ws, 1);
        check("mul_sign", ws_sign, 1);
        check("mul_mbc", c_mbc, 1);
        check("mul_ans_t", t_ans_op, 62);
        check("mul_ans_n", c_ans_op, 1);
        check("mul_busy_first", t_busy_first, 1);
        check("mul_busy_last", t_busy_last, 62);
        check("mul_busy_n", c_busy, 62);
        check("mul_ovf", c_ovf, 0);
        check("mul8_ans_t", t_d8_ans, 18);

        sign_a = 1'b1; sign_b = 1'b1;
        run("mul+div+io", 1, 1, 0, 3'd3, 1, 10, -1, -1, 66);
        check("coll_nota", c_nota, 0);
        check("coll_lshc", c_lshc, 0);
        check("coll_rsh", c_rsh, 30);
        check("coll_sign", ws_sign, 0);
        check("coll_ans_t", t_ans_op, 62);
        check("coll_ans_io", c_ans_io, 0);

        sign_a = 1'b0; sign_b = 1'b1;
        run("div", 0, 1, 0, 3'd0, 2, -1, -1, -1, 68);
        check("div_nota", c_nota, 1);
        check("div_sign", ws_sign, 1);
        check("div_lshb", c_lshb, 30);
        check("div_lshc", c_lshc, 30);
        check("div_sum", c_sum, 15);
        check("div_setc", c_setc, 15);
        check("div_mcb", c_mcb, 1);
        check("div_ans_t", t_ans_op, 63);
        check("div_ans_n", c_ans_op, 1);
        check("div_ovf", c_ovf, 0);
        check("div_busy_last", t_busy_last, 63);

        run("div_ovf", 0, 1, 0, 3'd0, 3, -1, -1, -1, 8);
        check("ovf_ans_t", t_ans_op, 3);
        check("ovf_t", t_ovf, 3);
        check("ovf_n", c_ovf, 1);
        check("ovf_lshb", c_lshb, 0);
        check("ovf_lshc", c_lshc, 0);
        check("ovf_sum", c_sum, 0);
        check("ovf_mcb", c_mcb, 0);
        check("ovf_busy_last", t_busy_last, 3);

        run("io0", 0, 0, 1, 3'd0, 0, -1, -1, -1, 8);
        check("io0_lshc", c_lshc, 0);
        check("io0_ans_t", t_ans_io, 1);
        check("io0_ans_op", c_ans_op, 0);
        run("io3", 0, 0, 1, 3'd3, 0, -1, -1, -1, 10);
        check("io3_lshc", c_lshc, 3);
        check("io3_ans_t", t_ans_io, 4);
        run("io4", 0, 0, 1, 3'd4, 0, -1, -1, -1, 10);
        check("io4_lshc", c_lshc, 4);
        check("io4_ans_t", t_ans_io, 5);
        run("io7", 0, 0, 1, 3'd7, 0, -1, -1, -1, 10);
        check("io7_lshc", c_lshc, 4);
        check("io7_ans_t", t_ans_io, 5);
        check("io7_ans_n", c_ans_io, 1);

        run("div_clear", 0, 1, 0, 3'd0, 2, -1, 20, -1, 66);
        check("clr_ans_n", c_ans_op, 0);
        check("clr_busy_last", t_busy_last, 20);
        run("div_again", 0, 1, 0, 3'd0, 2, -1, -1, -1, 68);
        check("again_ans_t", t_ans_op, 63);
        check("again_lshb", c_lshb, 30);

        run("mul_reset", 1, 0, 0, 3'd0, 1, -1, -1, 30, 66);
        check("rst_busy_last", t_busy_last, 30);
        check("rst_ans_n", c_ans_op, 0);
        check("rst_late_pulses", c_late, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
